// File: rtl/fht_ctrl.sv
// Address/sequencing controller for a 4-bank FHT engine: per-stage read, delayed write and twiddle addresses.
// Optional build macro FHT_BITREV_EN: bit-reverse the stage-0 read addresses inside the controller.
module fht_ctrl #(
  parameter int N         = 1024,
  parameter int BANK_SIZE = N / 4,
  parameter int A_BIT     = $clog2(BANK_SIZE),
  parameter int STAGES    = $clog2(N),
  parameter int LAT       = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  output logic             oST_ZERO,
  output logic             oST_LAST,
  output logic             o2ND_PART_SUBSEC,
  output logic [A_BIT-1:0] oSECTOR,
  output logic [A_BIT-1:0] oADDR_RD_0,
  output logic [A_BIT-1:0] oADDR_RD_1,
  output logic [A_BIT-1:0] oADDR_RD_2,
  output logic [A_BIT-1:0] oADDR_RD_3,
  output logic [A_BIT-1:0] oADDR_WR_0,
  output logic [A_BIT-1:0] oADDR_WR_1,
  output logic [A_BIT-1:0] oADDR_WR_2,
  output logic [A_BIT-1:0] oADDR_WR_3,
  output logic [A_BIT-1:0] oADDR_COEF,
  output logic             oWE_A,
  output logic             oWE_B,
  output logic             oSOURCE_DATA,
  output logic             oSOURCE_CONT,
  output logic             oRDY
);

  localparam int TW = $clog2(BANK_SIZE + LAT + 1);
  localparam int SW = $clog2(STAGES + 1);
  localparam logic [TW-1:0] T_BANK = TW'(BANK_SIZE);
  localparam logic [TW-1:0] T_LAT  = TW'(LAT);
  localparam logic [TW-1:0] T_END  = TW'(BANK_SIZE + LAT);
  localparam logic [SW-1:0] S_LAST = SW'(STAGES - 1);
  localparam logic [SW-1:0] S_ABIT = SW'(A_BIT);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // state_q is the FSM state observed by bound checkers.
  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [TW-1:0] time_q, time_d;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      time_q  <= time_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    time_d  = time_q;
    case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          state_d = ST_RUN;
          stage_d = '0;
          time_d  = '0;
        end
      end
      ST_RUN: begin
        if (time_q == T_END) begin
          time_d = '0;
          if (stage_q == S_LAST) begin
            state_d = ST_IDLE;
            stage_d = '0;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end else begin
          time_d = time_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FHT_BITREV_EN
  function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] x);
    for (int i = 0; i < A_BIT; i++) bitrev[i] = x[A_BIT-1-i];
  endfunction
`endif

  logic             busy, rd_phase, we, second;
  logic [SW-1:0]    l_log;
  logic [A_BIT-1:0] t, mask, off, rd_lo, rd_hi, sector, coef;

  // Sub-sector length L = 2^l_log; mask selects the offset inside a sub-sector.
  always_comb begin
    busy     = (state_q == ST_RUN);
    rd_phase = busy && (time_q < T_BANK);
    we       = busy && (time_q >= T_LAT) && (time_q < T_END);
    t        = time_q[A_BIT-1:0];
    l_log    = '0;
    rd_lo    = '0;
    rd_hi    = '0;
    sector   = '0;
    coef     = '0;
    second   = 1'b0;
    if (stage_q > S_ABIT + 1'b1) l_log = S_ABIT;
    else if (stage_q != '0)      l_log = stage_q - 1'b1;
    mask = ~({A_BIT{1'b1}} << l_log);
    off  = t & mask;
    if (rd_phase) begin
      if (stage_q == '0) begin
`ifdef FHT_BITREV_EN
        rd_lo = bitrev(t);
`else
        rd_lo = t;
`endif
        rd_hi = rd_lo;
      end else begin
        // Hartley partner: same sub-sector, offset mirrored to (L - off) mod L.
        rd_lo  = t;
        rd_hi  = (t & ~mask) | (('0 - off) & mask);
        sector = t >> l_log;
        second = |(off & ~(mask >> 1));
        coef   = off << (S_ABIT - l_log);
      end
    end
  end

  logic [A_BIT-1:0] pipe_lo_q [LAT];
  logic [A_BIT-1:0] pipe_hi_q [LAT];

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_lo_q[i] <= '0;
        pipe_hi_q[i] <= '0;
      end
    end else begin
      pipe_lo_q[0] <= rd_lo;
      pipe_hi_q[0] <= rd_hi;
      for (int i = 1; i < LAT; i++) begin
        pipe_lo_q[i] <= pipe_lo_q[i-1];
        pipe_hi_q[i] <= pipe_hi_q[i-1];
      end
    end
  end

  assign oADDR_RD_0       = rd_lo;
  assign oADDR_RD_1       = rd_lo;
  assign oADDR_RD_2       = rd_hi;
  assign oADDR_RD_3       = rd_hi;
  assign oADDR_WR_0       = pipe_lo_q[LAT-1];
  assign oADDR_WR_1       = pipe_lo_q[LAT-1];
  assign oADDR_WR_2       = pipe_hi_q[LAT-1];
  assign oADDR_WR_3       = pipe_hi_q[LAT-1];
  assign oSECTOR          = sector;
  assign o2ND_PART_SUBSEC = second;
  assign oADDR_COEF       = coef;
  // Even stages read B and write A; odd stages the reverse.
  assign oWE_A            = we & ~stage_q[0];
  assign oWE_B            = we & stage_q[0];
  assign oSOURCE_DATA     = busy & stage_q[0];
  assign oSOURCE_CONT     = busy;
  assign oRDY             = ~busy;
  assign oST_ZERO         = busy && (stage_q == '0);
  assign oST_LAST         = busy && (stage_q == S_LAST);

endmodule

// File: tb/tb_fht_ctrl.sv
// Directed bench for fht_ctrl at default parameters (N=1024, 4 banks of 256, LAT=4).
module tb_fht_ctrl;
  localparam int BANK   = 256;
  localparam int LAT    = 4;
  localparam int STAGES = 10;
  localparam int SLEN   = BANK + LAT + 1;
  localparam int TOTAL  = STAGES * SLEN;

  logic       iCLK = 1'b0;
  logic       iRESET = 1'b0;
  logic       iSTART = 1'b0;
  logic       oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
  logic [7:0] oSECTOR, oADDR_COEF;
  logic [7:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [7:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic       oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT, oRDY;
  logic [86:0] all_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 iCLK = ~iCLK;

  fht_ctrl dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST), .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC),
    .oSECTOR(oSECTOR),
    .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1), .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
    .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1), .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
    .oADDR_COEF(oADDR_COEF), .oWE_A(oWE_A), .oWE_B(oWE_B),
    .oSOURCE_DATA(oSOURCE_DATA), .oSOURCE_CONT(oSOURCE_CONT), .oRDY(oRDY)
  );

  assign all_out = {oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR,
                    oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
                    oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
                    oADDR_COEF, oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pulse_start();
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
  endtask

  function automatic int bitrev8(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) r = r * 2 + ((x >> i) & 1);
    return r;
  endfunction

  // reference addresses written straight from the stage/offset arithmetic
  task automatic model(input int s, input int t, output int lo, output int hi,
                       output int sec, output int sec2, output int coef);
    int l, base, off;
    lo = 0; hi = 0; sec = 0; sec2 = 0; coef = 0;
    if (t < BANK) begin
      if (s == 0) begin
`ifdef FHT_BITREV_EN
        lo = bitrev8(t);
`else
        lo = t;
`endif
        hi = lo;
      end else begin
        l = 1 << (s - 1);
        if (l > BANK) l = BANK;
        base = (t / l) * l;
        off  = t % l;
        lo   = t;
        hi   = base + ((l - off) % l);
        sec  = t / l;
        sec2 = (l > 1 && off >= l / 2) ? 1 : 0;
        coef = (off * (BANK / l)) % BANK;
      end
    end
  endtask

  initial begin
    int c, s, t, lo, hi, sec, sec2, coef;
    int rd_err, wr_err, we_err, flag_err, quiet;
    int we_cnt [STAGES];
    logic [7:0]  e1, lo8, hi8;
    logic [15:0] wexp;
    bit done, we_exp;

    e1 = 8'(bitrev8(1));
`ifndef FHT_BITREV_EN
    e1 = 8'd1;
`endif
    rd_err = 0; wr_err = 0; we_err = 0; flag_err = 0;
    for (int i = 0; i < STAGES; i++) we_cnt[i] = 0;

    repeat (3) tick();
    check("rst_rdy", oRDY, 1);
    check("rst_zero", |all_out, 0);
    @(negedge iCLK) iRESET = 1'b1;
    tick();
    check("idle_rdy", oRDY, 1);
    check("idle_zero", |all_out, 0);

    pulse_start();
    check("start_rdy", oRDY, 0);
    check("start_st_zero", oST_ZERO, 1);
    check("start_cont", oSOURCE_CONT, 1);
    repeat (LAT) exp_q.push_back(16'h0);

    c = 0;
    done = 0;
    while (!done) begin
      s = c / SLEN;
      t = c % SLEN;
      model(s, t, lo, hi, sec, sec2, coef);
      lo8 = 8'(lo);
      hi8 = 8'(hi);
      exp_q.push_back({lo8, hi8});
      wexp = exp_q.pop_front();
      if ({oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3} !== {lo8, lo8, hi8, hi8} ||
          oSECTOR !== 8'(sec) || o2ND_PART_SUBSEC !== 1'(sec2) || oADDR_COEF !== 8'(coef))
        rd_err++;
      if ({oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3} !==
          {wexp[15:8], wexp[15:8], wexp[7:0], wexp[7:0]})
        wr_err++;
      we_exp = (t >= LAT) && (t < BANK + LAT);
      if (oWE_A !== (we_exp && s % 2 == 0) || oWE_B !== (we_exp && s % 2 == 1)) we_err++;
      if (oST_ZERO !== (s == 0) || oST_LAST !== (s == STAGES - 1) || oSOURCE_DATA !== (s % 2 == 1) ||
          oSOURCE_CONT !== 1'b1 || oRDY !== 1'b0)
        flag_err++;
      if (s < STAGES && (oWE_A === 1'b1 || oWE_B === 1'b1)) we_cnt[s]++;

      if (c == 1) check("s0_t1_rd", {oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3}, {4{e1}});
      if (c == 3) check("s0_we_before_lat", oWE_A, 0);
      if (c == 4) check("s0_we_first", oWE_A, 1);
      if (c == 5) begin
        check("s0_t5_wr", {oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3}, {4{e1}});
        check("s0_t5_we", oWE_A, 1);
      end
      if (c == 259) check("s0_we_last", oWE_A, 1);
      if (c == 260) check("s0_tail_we", {oWE_A, oWE_B}, 0);
      if (c == SLEN + 10) check("s1_we_src", {oWE_B, oSOURCE_DATA, oWE_A}, 3'b110);
      if (c == 2 * SLEN + 5) begin
        check("s2_t5_rd2", oADDR_RD_2, 5);
        check("s2_t5_sec", {oSECTOR, 7'd0, o2ND_PART_SUBSEC}, {8'd2, 8'd1});
        check("s2_t5_coef", oADDR_COEF, 128);
      end
      if (c == 3 * SLEN + 5) begin
        check("s3_t5_rd01", {oADDR_RD_0, oADDR_RD_1}, {8'd5, 8'd5});
        check("s3_t5_rd23", {oADDR_RD_2, oADDR_RD_3}, {8'd7, 8'd7});
        check("s3_t5_sector", oSECTOR, 1);
        check("s3_t5_2nd", o2ND_PART_SUBSEC, 0);
        check("s3_t5_coef", oADDR_COEF, 64);
      end
      if (c == 3 * SLEN + 6) check("s3_t6", {oADDR_RD_2, 7'd0, o2ND_PART_SUBSEC, oADDR_COEF}, {8'd6, 8'd1, 8'd128});
      if (c == 3 * SLEN + 9) check("s3_t9_wr2", {oADDR_WR_2, 7'd0, oWE_B}, {8'd7, 8'd1});
      if (c == 3 * SLEN + 258) check("s3_tail_rd", {oADDR_RD_0, oADDR_RD_2, oADDR_COEF}, 0);
      if (c == 8 * SLEN + 130) check("s8_t130", {oADDR_RD_2, oSECTOR, oADDR_COEF}, {8'd254, 8'd1, 8'd4});
      if (c == 9 * SLEN + 200) begin
        check("s9_t200", {oADDR_RD_2, 7'd0, o2ND_PART_SUBSEC, oADDR_COEF}, {8'd56, 8'd1, 8'd200});
        check("s9_st_last", oST_LAST, 1);
      end

      // a start while busy, and one on the completion cycle, must both be ignored
      iSTART = (c == 1000 || c == TOTAL - 1);
      tick();
      c++;
      if (oRDY === 1'b1 || c > TOTAL + 400) done = 1;
    end
    iSTART = 1'b0;
    check("run_len", c, TOTAL);
    for (int i = 0; i < STAGES; i++) check($sformatf("we_cnt_s%0d", i), we_cnt[i], BANK);
    check("rd_model", rd_err, 0);
    check("wr_model", wr_err, 0);
    check("we_model", we_err, 0);
    check("flag_model", flag_err, 0);
    check("done_zero", |all_out, 0);
    tick();
    check("late_start_rdy", oRDY, 1);
    check("late_start_zero", oST_ZERO, 0);

    pulse_start();
    repeat (4 * SLEN + 50) tick();
    check("mid_s4_rd0", oADDR_RD_0, 50);
    check("mid_s4_we", oWE_A, 1);
    #2 iRESET = 1'b0;
    #1;
    check("mid_rst_rdy", oRDY, 1);
    check("mid_rst_zero", |all_out, 0);
    repeat (2) @(negedge iCLK);
    iRESET = 1'b1;
    quiet = 0;
    repeat (8) begin
      tick();
      if (oWE_A !== 1'b0 || oWE_B !== 1'b0 || oRDY !== 1'b1) quiet++;
    end
    check("post_rst_quiet", quiet, 0);

    pulse_start();
    check("restart_rdy", oRDY, 0);
    check("restart_st_zero", oST_ZERO, 1);
    tick();
    check("restart_t1_rd", {oADDR_RD_0, oADDR_RD_2}, {e1, e1});
    check("restart_t1_sec", {oSECTOR, oADDR_COEF}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
